// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU-side types: RAM status, word type and the
//                RAM arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // RAM status reported back to the requesting side
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [31:0] word_t;

    // RAM arbiter FSM encoding
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t c_IDLE   = 2'd0;
    localparam arb_state_t c_DGRANT = 2'd1;
    localparam arb_state_t c_IGRANT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Round-robin first-set finder. Scans req starting at ptr and
//                wrapping modulo CPUS; reports the first set index.
//  Ports       : req   in  CPUS   request vector
//                ptr   in  IDX_W  scan start index (0..CPUS-1)
//                valid out 1      any request set
//                idx   out IDX_W  first set index at or after ptr
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int CPUS  = 2,
    parameter int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic [CPUS-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int w_pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_pos = 0;
        for (int i = 0; i < CPUS; i++) begin
            // ptr is always < CPUS, so one subtraction is enough to wrap
            w_pos = int'(ptr) + i;
            if (w_pos >= CPUS) begin
                w_pos = w_pos - CPUS;
            end
            if (!valid && req[w_pos]) begin
                valid = 1'b1;
                idx   = w_pos[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares the single RAM port between the coherence data
//                channel and CPUS icache fetch channels. Data has priority,
//                icaches rotate round-robin, and a data streak limit keeps
//                icaches from starving. A grant is held until the RAM reports
//                ACCESS; the owner then sees wait low for exactly one cycle.
//  Ports       : CLK/RST            clock, synchronous active-high reset
//                iREN/iaddr         icache requests and addresses
//                iwait/iload        icache wait and read data
//                dREN/dWEN/daddr/dstore  data channel request
//                dwait/dload        data wait and read data
//                ramREN/ramWEN/ramaddr/ramstore  RAM command
//                ramload/ramstate   RAM response
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS        = 2,
    parameter int DSTREAK_MAX = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic                 dREN,
    input  logic                 dWEN,
    input  logic [31:0]          daddr,
    input  logic [31:0]          dstore,
    output logic                 dwait,
    output logic [31:0]          dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  ramstate_t            ramstate
);

    localparam int c_IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int c_DS_W  = $clog2(DSTREAK_MAX + 1);
    localparam logic [c_DS_W-1:0]  c_DS_MAX = c_DS_W'(DSTREAK_MAX);
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(CPUS - 1);

    arb_state_t          r_state;
    logic [c_IDX_W-1:0]  r_owner;
    logic [c_IDX_W-1:0]  r_rr_ptr;
    logic [c_DS_W-1:0]   r_dstreak;

    arb_state_t          w_state_nxt;
    logic [c_IDX_W-1:0]  w_owner_nxt;
    logic [c_IDX_W-1:0]  w_rr_ptr_nxt;
    logic [c_DS_W-1:0]   w_dstreak_nxt;

    logic                w_dreq;
    logic                w_any_i;
    logic                w_owner_req;
    logic                w_complete;
    logic                w_dcomplete;
    logic                w_icomplete;
    logic                w_arb;
    logic                w_data_win;
    logic                w_pick_valid;
    logic [c_IDX_W-1:0]  w_pick_idx;

    assign w_dreq  = dREN | dWEN;
    assign w_any_i = |iREN;

    // The current owner still wants the port; a drop ends the grant silently
    assign w_owner_req = ((r_state == c_DGRANT) && w_dreq) ||
                         ((r_state == c_IGRANT) && iREN[r_owner]);
    assign w_complete  = w_owner_req && (ramstate == ACCESS);
    assign w_dcomplete = w_complete && (r_state == c_DGRANT);
    assign w_icomplete = w_complete && (r_state == c_IGRANT);
    assign w_arb       = (r_state == c_IDLE) || w_complete;

    // Counter updates happen only on a completion
    always_comb begin
        w_dstreak_nxt = r_dstreak;
        w_rr_ptr_nxt  = r_rr_ptr;
        if (w_dcomplete) begin
            if (w_any_i) begin
                w_dstreak_nxt = (r_dstreak == c_DS_MAX) ? c_DS_MAX : r_dstreak + 1'b1;
            end else begin
                w_dstreak_nxt = '0;
            end
        end
        if (w_icomplete) begin
            w_dstreak_nxt = '0;
            w_rr_ptr_nxt  = (r_owner == c_LAST) ? '0 : r_owner + 1'b1;
        end
    end

    // Re-arbitration in a completion cycle sees the post-completion counters,
    // so the grant that follows a completion already reflects it: exactly
    // DSTREAK_MAX data completions before a pending icache gets the port,
    // and the icache just served moves to the back of the rotation.
    assign w_data_win = w_dreq && ((w_dstreak_nxt < c_DS_MAX) || !w_any_i);

    rr_picker #(
        .CPUS  (CPUS),
        .IDX_W (c_IDX_W)
    ) u_rr_picker (
        .req   (iREN),
        .ptr   (w_rr_ptr_nxt),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        if (w_arb) begin
            if (w_data_win) begin
                w_state_nxt = c_DGRANT;
            end else if (w_pick_valid) begin
                w_state_nxt = c_IGRANT;
                w_owner_nxt = w_pick_idx;
            end else begin
                w_state_nxt = c_IDLE;
            end
        end else if ((r_state != c_IDLE) && !w_owner_req) begin
            w_state_nxt = c_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_dstreak <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_dstreak <= w_dstreak_nxt;
        end
    end

    assign dload = ramload;

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        iwait    = '1;
        iload    = '0;
        case (r_state)
            c_DGRANT: begin
                // A write wins when both enables are raised
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = ~w_complete;
            end
            c_IGRANT: begin
                ramREN           = 1'b1;
                ramaddr          = iaddr[r_owner];
                iwait[r_owner]   = ~w_complete;
                iload[r_owner]   = ramload;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter. Directed stimulus pushes
//                the expected completions into a scoreboard queue; a monitor
//                pops and compares whenever a wait drops low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS        = 2;
    localparam int DSTREAK_MAX = 4;
    localparam int WHO_D       = 9;
    localparam logic [31:0] LOAD_XOR = 32'hA5A5_0000;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [CPUS-1:0]       iREN;
    logic [CPUS-1:0][31:0] iaddr;
    logic [CPUS-1:0]       iwait;
    logic [CPUS-1:0][31:0] iload;
    logic                  dREN, dWEN;
    logic [31:0]           daddr, dstore;
    logic                  dwait;
    logic [31:0]           dload;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    ramstate_t             ramstate;

    ram_arbiter #(.CPUS(CPUS), .DSTREAK_MAX(DSTREAK_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM data model: read data is the address with a fixed upper pattern
    assign ramload = ramaddr ^ LOAD_XOR;

    typedef struct {
        int          who;
        logic [31:0] addr;
        logic [31:0] load;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input int who, input logic [31:0] addr);
        exp_t e;
        e.who  = who;
        e.addr = addr;
        e.load = addr ^ LOAD_XOR;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    // Park the port: drop every request, let the arbiter fall back to IDLE
    task automatic quiesce();
        ramstate = BUSY;
        dREN = 1'b0;
        dWEN = 1'b0;
        iREN = '0;
        step();
        step();
        neg();
        chk("idle_ren", {63'b0, ramREN}, 64'd0);
        chk("idle_wen", {63'b0, ramWEN}, 64'd0);
        step();
    endtask

    // Monitor: invariants every cycle, scoreboard on each completion
    logic [CPUS:0] m_lows;
    int            m_who;
    logic [31:0]   m_load;
    exp_t          m_exp;

    always @(negedge CLK) begin
        m_lows = ~{dwait, iwait};
        checks++;
        if ($countones(m_lows) > 1) begin
            errors++;
            $display("FAIL one_wait_low: lows=%b expected at most one", m_lows);
        end
        checks++;
        if (ramREN && ramWEN) begin
            errors++;
            $display("FAIL ren_wen_excl: ramREN=%b ramWEN=%b expected not both", ramREN, ramWEN);
        end
        if (m_lows != '0) begin
            m_who = -1;
            if (!dwait) m_who = WHO_D;
            for (int k = 0; k < CPUS; k++) begin
                if (!iwait[k]) m_who = k;
            end
            m_load = (m_who == WHO_D) ? dload : iload[m_who];
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completion: who=%0d addr=%0h expected none", m_who, ramaddr);
            end else begin
                m_exp = sb.pop_front();
                if (m_who != m_exp.who || ramaddr != m_exp.addr || m_load != m_exp.load) begin
                    errors++;
                    $display("FAIL completion: who=%0d addr=%0h load=%0h expected who=%0d addr=%0h load=%0h",
                             m_who, ramaddr, m_load, m_exp.who, m_exp.addr, m_exp.load);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        iREN = '0;
        iaddr = '0;
        dREN = 1'b0;
        dWEN = 1'b0;
        daddr = '0;
        dstore = '0;
        ramstate = FREE;

        // Reset state
        step();
        step();
        neg();
        chk("rst_ren",   {63'b0, ramREN}, 64'd0);
        chk("rst_wen",   {63'b0, ramWEN}, 64'd0);
        chk("rst_addr",  {32'b0, ramaddr}, 64'd0);
        chk("rst_store", {32'b0, ramstore}, 64'd0);
        chk("rst_dwait", {63'b0, dwait}, 64'd1);
        chk("rst_iwait", {62'b0, iwait}, 64'd3);
        chk("rst_iload", iload, 64'd0);
        step();
        RST = 1'b0;

        // 1: data write, two BUSY cycles then ACCESS
        dWEN = 1'b1;
        daddr = 32'h40;
        dstore = 32'hCAFEF00D;
        ramstate = BUSY;
        expect_txn(WHO_D, 32'h40);
        neg();
        chk("t1_req_cycle_wen",   {63'b0, ramWEN}, 64'd0);
        chk("t1_req_cycle_dwait", {63'b0, dwait}, 64'd1);
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 3) ramstate = ACCESS;
            neg();
            chk("t1_wen",   {63'b0, ramWEN}, 64'd1);
            chk("t1_ren",   {63'b0, ramREN}, 64'd0);
            chk("t1_addr",  {32'b0, ramaddr}, 64'h40);
            chk("t1_store", {32'b0, ramstore}, 64'hCAFEF00D);
            chk("t1_dwait", {63'b0, dwait}, (c == 3) ? 64'd0 : 64'd1);
        end
        step();
        quiesce();

        // 2: both icaches, ACCESS every cycle -> 0,1,0,1
        iaddr[0] = 32'h100;
        iaddr[1] = 32'h200;
        iREN = 2'b11;
        ramstate = ACCESS;
        expect_txn(0, 32'h100);
        expect_txn(1, 32'h200);
        expect_txn(0, 32'h100);
        expect_txn(1, 32'h200);
        for (int c = 1; c <= 4; c++) begin
            step();
            neg();
            chk("t2_addr", {32'b0, ramaddr}, (c % 2 == 1) ? 64'h100 : 64'h200);
        end
        step();
        quiesce();

        // 3: data streak limit with iREN[0] pending
        dREN = 1'b1;
        daddr = 32'h80;
        iREN = 2'b01;
        ramstate = ACCESS;
        for (int c = 1; c <= 4; c++) expect_txn(WHO_D, 32'h80);
        expect_txn(0, 32'h100);
        expect_txn(WHO_D, 32'h80);
        for (int c = 1; c <= 6; c++) begin
            step();
            neg();
            chk("t3_addr", {32'b0, ramaddr}, (c == 5) ? 64'h100 : 64'h80);
        end
        step();
        quiesce();

        // 4a: read and write together -> write only
        dREN = 1'b1;
        dWEN = 1'b1;
        daddr = 32'h44;
        ramstate = ACCESS;
        expect_txn(WHO_D, 32'h44);
        step();
        neg();
        chk("t4_wen", {63'b0, ramWEN}, 64'd1);
        chk("t4_ren", {63'b0, ramREN}, 64'd0);
        step();
        quiesce();

        // 4b: ERROR never completes
        dREN = 1'b1;
        daddr = 32'h48;
        ramstate = ERROR;
        for (int c = 1; c <= 8; c++) begin
            step();
            neg();
            chk("t4_error_dwait", {63'b0, dwait}, 64'd1);
        end
        chk("t4_error_ren",  {63'b0, ramREN}, 64'd1);
        chk("t4_error_addr", {32'b0, ramaddr}, 64'h48);
        step();
        quiesce();

        // 5: icache 1 drops mid-grant; rotation pointer must stay on 1
        iREN = 2'b10;
        ramstate = BUSY;
        step();
        neg();
        chk("t5_addr",  {32'b0, ramaddr}, 64'h200);
        chk("t5_ren",   {63'b0, ramREN}, 64'd1);
        chk("t5_iwait", {62'b0, iwait}, 64'd3);
        step();
        iREN = 2'b00;
        neg();
        chk("t5_drop_iwait", {62'b0, iwait}, 64'd3);
        step();
        neg();
        chk("t5_idle_ren", {63'b0, ramREN}, 64'd0);
        step();
        iREN = 2'b11;
        ramstate = ACCESS;
        expect_txn(1, 32'h200);
        expect_txn(0, 32'h100);
        repeat (3) step();
        quiesce();

        // 6: reset during DGRANT clears the streak
        dREN = 1'b1;
        daddr = 32'h4C;
        iREN = 2'b01;
        ramstate = ACCESS;
        for (int c = 1; c <= 3; c++) expect_txn(WHO_D, 32'h4C);
        repeat (4) step();
        ramstate = BUSY;
        RST = 1'b1;
        neg();
        chk("t6_rst_cycle_ren", {63'b0, ramREN}, 64'd1);
        step();
        RST = 1'b0;
        ramstate = ACCESS;
        for (int c = 1; c <= 4; c++) expect_txn(WHO_D, 32'h4C);
        expect_txn(0, 32'h100);
        neg();
        chk("t6_after_rst_ren",   {63'b0, ramREN}, 64'd0);
        chk("t6_after_rst_wen",   {63'b0, ramWEN}, 64'd0);
        chk("t6_after_rst_dwait", {63'b0, dwait}, 64'd1);
        chk("t6_after_rst_iwait", {62'b0, iwait}, 64'd3);
        repeat (6) step();
        quiesce();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
